click_classifier: RTL and testbench

CLICK_CLASSIFIER -- requirements
Module: click_classifier

---
 rtl/click_classifier_pkg.sv | 30 +++
 rtl/click_classifier_gap_timer.sv | 37 +++
 rtl/click_classifier.sv | 117 +++++++++++
 tb/tb_click_classifier.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/click_classifier_pkg.sv
//==============================================================================
// Module   : click_classifier_pkg
// Purpose  : Shared codes, FSM states and defaults. Macro CLICK_TRIPLE_EN enables triple clicks.
// Revision : 1.0
//==============================================================================
`default_nettype none

package click_classifier_pkg;

   localparam logic [1:0] CLK_SINGLE = 2'b01;
   localparam logic [1:0] CLK_DOUBLE = 2'b10;
   localparam logic [1:0] CLK_TRIPLE = 2'b11;

   localparam int unsigned DEFAULT_WINDOW = 25000000;
   localparam int unsigned DEFAULT_TW     = 25;

`ifdef CLICK_TRIPLE_EN
   localparam logic [1:0] MAXC = CLK_TRIPLE;
`else
   localparam logic [1:0] MAXC = CLK_DOUBLE;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/click_classifier_gap_timer.sv
//==============================================================================
// Module   : gap_timer
// Purpose  : Inter-press gap counter with clear, enable and terminal-count flag.
// Revision : 1.0
//==============================================================================
`default_nettype none

module gap_timer #(
   parameter int unsigned WINDOW = click_classifier_pkg::DEFAULT_WINDOW,
   parameter int unsigned TW     = click_classifier_pkg::DEFAULT_TW
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

   logic [TW-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/click_classifier.sv
//==============================================================================
// Module   : click_classifier
// Purpose  : Groups press pulses into single/double(/triple with CLICK_TRIPLE_EN) events.
// Revision : 1.0
//==============================================================================
`default_nettype none

module click_classifier
   import click_classifier_pkg::*;
#(
   parameter int unsigned WINDOW = DEFAULT_WINDOW,
   parameter int unsigned TW     = DEFAULT_TW
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       press,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   input  logic       evt_ready,
   output logic       overrun,
   input  logic       clr_overrun,
   output logic [7:0] evt_total
);

   state_t     state;
   state_t     next_state;
   logic [1:0] count;
   logic [1:0] next_count;
   logic       timeout;
   logic       emit;
   logic [1:0] emit_code;
   logic       can_load;

   // Timer is held at zero while idle and restarted by every press.
   gap_timer #(
      .WINDOW (WINDOW),
      .TW     (TW)
   ) u_gap_timer (
      .clock    (clock),
      .reset    (reset),
      .clear    ((state == ST_IDLE) || press),
      .enable   (state == ST_GAP),
      .terminal (timeout)
   );

   always_comb begin
      next_state = state;
      next_count = count;
      emit       = 1'b0;
      emit_code  = count;
      case (state)
         ST_IDLE: begin
            if (press) begin
               next_state = ST_GAP;
               next_count = CLK_SINGLE;
            end
         end
         ST_GAP: begin
            // A press in the timeout cycle takes priority and extends the group.
            if (press) begin
               if ((count + 2'd1) == MAXC) begin
                  emit       = 1'b1;
                  emit_code  = MAXC;
                  next_state = ST_IDLE;
                  next_count = 2'd0;
               end else begin
                  next_count = count + 2'd1;
               end
            end else if (timeout) begin
               emit       = 1'b1;
               emit_code  = count;
               next_state = ST_IDLE;
               next_count = 2'd0;
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_count = 2'd0;
         end
      endcase
   end

   assign can_load = !evt_valid || evt_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         count     <= 2'd0;
         evt_valid <= 1'b0;
         evt_code  <= 2'b00;
         overrun   <= 1'b0;
         evt_total <= 8'd0;
      end else begin
         state <= next_state;
         count <= next_count;

         if (emit && can_load) begin
            evt_valid <= 1'b1;
            evt_code  <= emit_code;
            evt_total <= evt_total + 8'd1;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
         end

         // A drop in the same cycle as a clear leaves the flag set.
         if (emit && !can_load) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_click_classifier.sv
//==============================================================================
// Module   : tb_click_classifier
// Purpose  : Scoreboard bench for click_classifier at WINDOW=10 (CLICK_TRIPLE_EN aware).
// Revision : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_click_classifier;
   import click_classifier_pkg::*;

   localparam int unsigned WIN = 10;

   logic       clock       = 1'b0;
   logic       reset       = 1'b0;
   logic       press       = 1'b0;
   logic       evt_ready   = 1'b1;
   logic       clr_overrun = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       overrun;
   logic [7:0] evt_total;

   int         cyc         = 0;
   int         applied     = 0;
   int         miscompares = 0;
   logic [7:0] exp_total   = 8'd0;

   typedef struct {
      logic [1:0] code;
      int         at;
   } exp_t;

   exp_t sb[$];

   click_classifier #(
      .WINDOW (WIN),
      .TW     (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .press       (press),
      .evt_valid   (evt_valid),
      .evt_code    (evt_code),
      .evt_ready   (evt_ready),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .evt_total   (evt_total)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every accepted event is matched against the scoreboard.
   always @(negedge clock) begin
      if (reset && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_evt_valid", 32'(evt_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("evt_code", 32'(evt_code), 32'(e.code));
            if (e.at >= 0) check("evt_cycle", cyc, e.at);
         end
      end
   end

   task automatic tick(input logic p);
      @(posedge clock);
      #1;
      press = p;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic expect_evt(input logic [1:0] c, input int at);
      sb.push_back('{c, at});
      exp_total = exp_total + 8'd1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
      check({tag, "_evt_code"},  32'(evt_code),  32'd0);
      check({tag, "_overrun"},   32'(overrun),   32'd0);
      check({tag, "_evt_total"}, 32'(evt_total), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int p;

      #12;
      check_all_zero("reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      // Single press, consumer always ready.
      tick(1'b1); p = cyc;
      expect_evt(CLK_SINGLE, p + 11);
      idle(15);
      check("single_total", 32'(evt_total), 32'd1);

`ifdef CLICK_TRIPLE_EN
      tick(1'b1); p = cyc;
      idle(8); tick(1'b1);
      idle(8); tick(1'b1);
      expect_evt(CLK_TRIPLE, p + 19);
      idle(15);

      // Two presses then timeout give a double.
      tick(1'b1); p = cyc;
      idle(4); tick(1'b1);
      expect_evt(CLK_DOUBLE, p + 16);
      idle(15);
`else
      tick(1'b1); p = cyc;
      idle(4); tick(1'b1);
      expect_evt(CLK_DOUBLE, p + 6);
      idle(15);

      // Press exactly in the timeout cycle still joins the group.
      tick(1'b1); p = cyc;
      idle(9); tick(1'b1);
      expect_evt(CLK_DOUBLE, p + 11);
      idle(15);

      // Third press starts a fresh group; no triple code exists.
      tick(1'b1); p = cyc;
      idle(2); tick(1'b1);
      expect_evt(CLK_DOUBLE, p + 4);
      idle(2); tick(1'b1);
      expect_evt(CLK_SINGLE, p + 17);
      idle(15);
`endif
      check("group_total", 32'(evt_total), 32'(exp_total));

      // Slot full, consumer stalled: second event dropped.
      evt_ready = 1'b0;
      tick(1'b1);
      expect_evt(CLK_SINGLE, -1);
      idle(29); tick(1'b1);
      idle(15);
      check("stall_evt_valid", 32'(evt_valid), 32'd1);
      check("stall_evt_code",  32'(evt_code),  32'(CLK_SINGLE));
      check("stall_overrun",   32'(overrun),   32'd1);
      check("stall_total",     32'(evt_total), 32'(exp_total));
      @(posedge clock); #1 clr_overrun = 1'b1;
      @(posedge clock); #1 clr_overrun = 1'b0;
      check("clr_overrun", 32'(overrun), 32'd0);

      // Clear coinciding with a new drop: set wins.
      tick(1'b1); p = cyc;
      idle(9);
      @(posedge clock); #1 clr_overrun = 1'b1;
      @(posedge clock); #1 clr_overrun = 1'b0;
      check("set_wins_overrun", 32'(overrun),   32'd1);
      check("set_wins_code",    32'(evt_code),  32'(CLK_SINGLE));
      check("set_wins_total",   32'(evt_total), 32'(exp_total));
      evt_ready = 1'b1;
      idle(3);
      check("drain_evt_valid", 32'(evt_valid), 32'd0);

      // Reset in the middle of a gap discards the group.
      tick(1'b1);
      idle(4);
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      exp_total = 8'd0;
      idle(20);
      check_all_zero("post_reset");

      // 256 singles wrap the total counter.
      for (int i = 0; i < 256; i++) begin
         tick(1'b1); p = cyc;
         expect_evt(CLK_SINGLE, p + 11);
         idle(11);
         if (i == 254) check("total_255", 32'(evt_total), 32'd255);
      end
      check("total_wrap", 32'(evt_total), 32'd0);

      idle(5);
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
